demux4_stream: RTL and testbench
================================

# demux4_stream

Four-way stream demultiplexer: the distributing counterpart of the 4:1 word mux. Accepts one 32-bit word per cycle on a valid/ready input and steers it by a 2-bit select (s1,s0) into one of four independent output channels. Each channel has a 2-entry FIFO, so a stalled consumer does not block traffic bound for the other channels. Sits between a single producer, such as a register-file read or a bus response, and four consumers.

## Interface
- `WIDTH`, 32: data word width.
- `DEPTH`, 2: entries per output FIFO; fixed at 2, and other values are unsupported.
- `clk`  in  1  rising-edge clock.
- `rst_n`  in  1  reset, synchronous, active-low.
- `in_data`  in  WIDTH  word to route.
- `in_s0`  in  1  select LSB.
- `in_s1`  in  1  select MSB. Channel index = {in_s1,in_s0}.
- `in_valid`  in  1  word and select are valid.
- `in_ready`  out  1  block can accept this cycle.
- `in_bcast`  in  1  broadcast request. Present only with DEMUX4_BCAST_EN.
- `out_data[0..3]`  out  4×WIDTH  head word of each channel FIFO.
- `out_valid[0..3]`  out  4  channel FIFO non-empty.
- `out_ready[0..3]`  in  4  consumer takes head word.
- `out_level[0..3]`  out  4×2  per-channel occupancy, 0 to 2.

## Operation
- Handshakes:
  - Input transfer occurs when `in_valid && in_ready`.
  - Output transfer on channel k occurs when `out_valid[k] && out_ready[k]`.
- Routing: an accepted word is written to the tail of FIFO k, where k = {s1,s0]: 00→0, 01→1, 10→2, 11→3.
- `in_ready`:
  - Equals 1 when the selected FIFO has level < 2.
  - Is a function of the select and registered levels only. It has no combinational path from `out_ready`.
- FIFO k operations on the same edge:
  - Push only: level +1.
  - Pop only: level −1.
  - Push and pop: level unchanged, and the head advances.
  - At level 2, a push is impossible because `in_ready` is low, even when a pop occurs that cycle.
- `out_data[k]` is the FIFO head. It is don't-care when `out_valid[k]`=0, but in practice it holds its last value.
- Word order is preserved per channel. There is no ordering guarantee across channels.
- When `in_valid`=0, no state changes except pops.

## Timing
- Latency: a word accepted at edge N shows `out_valid[k]`=1 and `out_data[k]`=word after edge N. It is poppable at edge N+1 at the earliest.
- Throughput:
  - One word per cycle into any single channel while its consumer keeps `out_ready` high (level alternates 1↔1).
  - Back-to-back words to different channels are accepted every cycle.
- Reset (`rst_n`=0 at an edge):
  - All levels become 0; `out_valid`=0; `out_data`=0; FIFO pointers become 0.
  - `in_ready` is 0 for the whole cycle in which `rst_n` is low.
- Reset mid-operation discards all buffered words. No transfer completes on a reset edge.
- Full channel: `in_ready`=0 only while the selected channel is full. A changed select can make `in_ready` rise in the same cycle.

## Configuration
- Macro: `DEMUX4_BCAST_EN`.
- Defined:
  - The `in_bcast` port exists.
  - When `in_bcast`=1 with valid, the word is pushed into all four FIFOs and the select is ignored.
  - `in_ready` = AND of (level<2) over all four channels.
  - Pops proceed independently per channel.
- Undefined: no `in_bcast` port. Behaviour is identical to the macro defined with `in_bcast` tied to 0.

## Structure
- Package `demux4_pkg`:
  - `NPORTS`=4.
  - `DEFAULT_WIDTH`=32.
  - typedef `chan_sel_t` (logic [1:0]).
  - typedef `level_t` (logic [1:0]).
- Sub-module `demux_fifo2`: 2-entry FIFO with push/pop, data, valid and level outputs, instantiated four times.
- Top level: select decode, push enables, `in_ready` logic, optional broadcast.

## Test plan
1. Reset, then assert `rst_n` → all `out_valid`=0, `out_level`=0, `in_ready`=1.
2. Send 0xA0000000, 0xB1111111, 0xC2222222, 0xD3333333 with sel 00, 01, 10, 11 on consecutive cycles, all `out_ready`=0 → each channel has level 1 with the matching word. `in_ready` stays 1.
3. Send three words 0x1, 0x2, 0x3 to channel 2 with `out_ready[2]`=0 → `in_ready` drops after the second word and level is 2. Raising `out_ready[2]` pops 0x1. 0x3 is then accepted and popped after 0x2.
4. Stream 100 words to channel 1 with `out_ready[1]`=1 → one acceptance per cycle, in-order delivery, level never exceeds 1.
5. Fill channel 0 (level 2), then pulse `rst_n`=0 → levels become 0, `out_valid` becomes 0, and the old words never appear.
6. With `DEMUX4_BCAST_EN`: send 0xFFFF0000 with `in_bcast`=1 → all four channels hold it at level 1. With channel 3 full, `in_ready`=0 while `in_bcast`=1.

Source files
------------

// File: rtl/demux4_pkg.sv
// Shared constants and types for the four-way stream demultiplexer.
package demux4_pkg;

  localparam int NPORTS        = 4;
  localparam int DEFAULT_WIDTH = 32;

  typedef logic [1:0] chan_sel_t;
  typedef logic [1:0] level_t;

endpackage

// File: rtl/demux_fifo2.sv
// Two-entry FIFO for one demux output channel; the head word is visible as soon as it is written.
module demux_fifo2
  import demux4_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] wr_data,
  output logic [WIDTH-1:0] head,
  output logic             valid,
  output level_t           level
);

  localparam level_t LEVEL_FULL = 2'd2;

  logic [WIDTH-1:0] mem [2];
  logic             wr_ptr;
  logic             rd_ptr;
  logic             do_push;
  logic             do_pop;

  // Guard both sides locally so a misbehaving caller can never corrupt the level.
  assign do_push = push && (level != LEVEL_FULL);
  assign do_pop  = pop && valid;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      mem[0] <= '0;
      mem[1] <= '0;
      wr_ptr <= 1'b0;
      rd_ptr <= 1'b0;
      level  <= '0;
    end else begin
      if (do_push) begin
        mem[wr_ptr] <= wr_data;
        wr_ptr      <= ~wr_ptr;
      end
      if (do_pop) begin
        rd_ptr <= ~rd_ptr;
      end
      case ({do_push, do_pop})
        2'b10:   level <= level + 2'd1;
        2'b01:   level <= level - 2'd1;
        default: level <= level;
      endcase
    end
  end

  assign head  = mem[rd_ptr];
  assign valid = (level != 2'd0);

endmodule

// File: rtl/demux4_stream.sv
// Four-way stream demultiplexer with a 2-entry FIFO per output channel.
// Optional broadcast input enabled by DEMUX4_BCAST_EN.
module demux4_stream
  import demux4_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH,
  parameter int DEPTH = 2
) (
  input  logic                           clk,
  input  logic                           rst_n,
  input  logic [WIDTH-1:0]               in_data,
  input  logic                           in_s0,
  input  logic                           in_s1,
  input  logic                           in_valid,
  output logic                           in_ready,
`ifdef DEMUX4_BCAST_EN
  input  logic                           in_bcast,
`endif
  output logic [NPORTS-1:0][WIDTH-1:0]   out_data,
  output logic [NPORTS-1:0]              out_valid,
  input  logic [NPORTS-1:0]              out_ready,
  output level_t [NPORTS-1:0]            out_level
);

  chan_sel_t         sel;
  logic              bcast;
  logic [NPORTS-1:0] full;
  logic [NPORTS-1:0] push;

  assign sel = {in_s1, in_s0};

`ifdef DEMUX4_BCAST_EN
  assign bcast = in_bcast;
`else
  assign bcast = 1'b0;
`endif

  always_comb begin
    full = '0;
    for (int k = 0; k < NPORTS; k++) begin
      full[k] = (out_level[k] == level_t'(DEPTH));
    end
  end

  // Depends only on select and registered levels, never on out_ready.
  assign in_ready = rst_n && (bcast ? ~|full : ~full[sel]);

  always_comb begin
    push = '0;
    for (int k = 0; k < NPORTS; k++) begin
      push[k] = in_valid && in_ready && (bcast || (sel == chan_sel_t'(k)));
    end
  end

  for (genvar g = 0; g < NPORTS; g++) begin : g_chan
    demux_fifo2 #(
      .WIDTH (WIDTH)
    ) u_fifo (
      .clk     (clk),
      .rst_n   (rst_n),
      .push    (push[g]),
      .pop     (out_ready[g]),
      .wr_data (in_data),
      .head    (out_data[g]),
      .valid   (out_valid[g]),
      .level   (out_level[g])
    );
  end

endmodule

// File: tb/tb_demux4_stream.sv
// Self-checking bench for demux4_stream: directed steps plus random traffic against a queue model.
module tb_demux4_stream;
  import demux4_pkg::*;

  logic                        clk = 1'b0;
  logic                        rst_n;
  logic [31:0]                 in_data;
  logic                        in_s0, in_s1, in_valid, in_bcast;
  logic                        in_ready;
  logic [NPORTS-1:0][31:0]     out_data;
  logic [NPORTS-1:0]           out_valid;
  logic [NPORTS-1:0]           out_ready;
  level_t [NPORTS-1:0]         out_level;

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;

  logic [31:0] q [NPORTS][$];

  always #5 clk = ~clk;

  demux4_stream #(.WIDTH(32), .DEPTH(2)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_data   (in_data),
    .in_s0     (in_s0),
    .in_s1     (in_s1),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
`ifdef DEMUX4_BCAST_EN
    .in_bcast  (in_bcast),
`endif
    .out_data  (out_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_level (out_level)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic bit model_ready();
    bit r;
    if (!rst_n) return 1'b0;
`ifdef DEMUX4_BCAST_EN
    if (in_bcast) begin
      r = 1'b1;
      for (int k = 0; k < NPORTS; k++) if (q[k].size() >= 2) r = 1'b0;
      return r;
    end
`endif
    return q[{in_s1, in_s0}].size() < 2;
  endfunction

  function automatic bit is_bcast();
`ifdef DEMUX4_BCAST_EN
    return in_bcast;
`else
    return 1'b0;
`endif
  endfunction

  task automatic check_outputs();
    for (int k = 0; k < NPORTS; k++) begin
      chk($sformatf("valid%0d", k), 64'(out_valid[k]), 64'(q[k].size() != 0));
      chk($sformatf("level%0d", k), 64'(out_level[k]), 64'(q[k].size()));
      if (q[k].size() != 0) chk($sformatf("data%0d", k), 64'(out_data[k]), 64'(q[k][0]));
    end
    chk("in_ready", 64'(in_ready), 64'(model_ready()));
  endtask

  // One clock: check before the edge, then advance the model with what the edge transfers.
  task automatic cycle(output bit accepted);
    bit          fire;
    bit [3:0]    pops;
    logic [31:0] d;
    @(negedge clk);
    check_outputs();
    fire = in_valid && model_ready();
    for (int k = 0; k < NPORTS; k++) pops[k] = out_ready[k] && (q[k].size() != 0);
    d = in_data;
    @(posedge clk);
    cyc++;
    if (!rst_n) begin
      for (int k = 0; k < NPORTS; k++) q[k].delete();
      accepted = 1'b0;
    end else begin
      for (int k = 0; k < NPORTS; k++) if (pops[k]) void'(q[k].pop_front());
      if (fire) begin
        for (int k = 0; k < NPORTS; k++)
          if (is_bcast() || (k == int'({in_s1, in_s0}))) q[k].push_back(d);
      end
      accepted = fire;
    end
    #1;
  endtask

  task automatic send(input logic [31:0] d, input logic [1:0] sel, input int budget);
    bit acc;
    in_data  = d;
    {in_s1, in_s0} = sel;
    in_valid = 1'b1;
    acc = 1'b0;
    for (int i = 0; i < budget && !acc; i++) cycle(acc);
    if (!acc) begin
      checks++;
      failures++;
      $error("FAIL send_timeout observed=not_accepted expected=accepted word=%0h", d);
    end
    in_valid = 1'b0;
  endtask

  task automatic idle(input int n);
    bit acc;
    for (int i = 0; i < n; i++) cycle(acc);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    idle(1);
    rst_n = 1'b1;
  endtask

  initial begin
    bit acc;
    int start;
    rst_n = 1'b0; in_data = '0; in_s0 = 0; in_s1 = 0; in_valid = 0; in_bcast = 0;
    out_ready = '0;
    repeat (2) @(posedge clk);
    #1;

    // 1: reset state, in_ready low while reset held
    idle(1);
    for (int k = 0; k < NPORTS; k++) chk($sformatf("rst_data%0d", k), 64'(out_data[k]), 64'h0);
    rst_n = 1'b1;
    idle(1);

    // 2: one word per channel on consecutive cycles
    send(32'hA000_0000, 2'd0, 2);
    send(32'hB111_1111, 2'd1, 2);
    send(32'hC222_2222, 2'd2, 2);
    send(32'hD333_3333, 2'd3, 2);
    idle(1);
    do_reset();

    // 3: fill channel 2, block the third word, then release
    send(32'h1, 2'd2, 2);
    send(32'h2, 2'd2, 2);
    in_data = 32'h3; {in_s1, in_s0} = 2'd2; in_valid = 1'b1;
    idle(2);
    chk("ch2_full_ready", 64'(in_ready), 64'h0);
    in_s1 = 1'b0;
    #1;
    chk("sel_change_ready", 64'(in_ready), 64'h1);
    in_s1 = 1'b1;
    out_ready[2] = 1'b1;
    send(32'h3, 2'd2, 4);
    idle(3);
    chk("ch2_drained", 64'(out_valid[2]), 64'h0);
    out_ready = '0;

    // 4: streaming into channel 1
    out_ready[1] = 1'b1;
    start = cyc;
    for (int i = 0; i < 100; i++) begin
      send($urandom, 2'd1, 3);
      chk("stream_lvl_le1", 64'(out_level[1] <= 2'd1), 64'h1);
    end
    chk("stream_rate", 64'(cyc - start), 64'd100);
    idle(2);
    out_ready = '0;

    // 5: reset discards buffered words
    send(32'h5555_0001, 2'd0, 2);
    send(32'h5555_0002, 2'd0, 2);
    chk("ch0_full", 64'(out_level[0]), 64'h2);
    do_reset();
    out_ready = '1;
    idle(3);
    out_ready = '0;

`ifdef DEMUX4_BCAST_EN
    // 6: broadcast
    in_bcast = 1'b1;
    send(32'hFFFF_0000, 2'd1, 2);
    for (int k = 0; k < NPORTS; k++) chk($sformatf("bc_level%0d", k), 64'(out_level[k]), 64'h1);
    in_bcast = 1'b0;
    send(32'h33, 2'd3, 2);
    in_bcast = 1'b1; in_valid = 1'b1; {in_s1, in_s0} = 2'd0;
    #1;
    chk("bc_blocked", 64'(in_ready), 64'h0);
    in_valid = 1'b0; in_bcast = 1'b0;
    do_reset();
`endif

    // random traffic
    for (int i = 0; i < 400; i++) begin
      in_data  = $urandom;
      {in_s1, in_s0} = 2'($urandom_range(0, 3));
      in_valid = ($urandom_range(0, 3) != 0);
`ifdef DEMUX4_BCAST_EN
      in_bcast = ($urandom_range(0, 7) == 0);
`endif
      out_ready = 4'($urandom);
      if (i == 200) rst_n = 1'b0;
      cycle(acc);
      rst_n = 1'b1;
    end
    in_valid = 1'b0; in_bcast = 1'b0;
    out_ready = '1;
    idle(3);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule
